// File: rtl/mem_access.sv
// RV64 memory-access stage: issues one data-memory request per load/store,
// aligns and extends load data, and hands one registered retire to writeback.
module mem_access (
  input  logic        clk,
  input  logic        resetn,
  input  logic        ex_valid_i,
  output logic        ex_ready_o,
  input  logic [63:0] alu_res_i,
  input  logic [63:0] store_data_i,
  input  logic [1:0]  mem_op_i,
  input  logic [1:0]  mem_size_i,
  input  logic        mem_unsigned_i,
  input  logic [4:0]  rd_i,
  input  logic        rd_we_i,
  output logic        dmem_req_valid_o,
  input  logic        dmem_req_ready_i,
  output logic [63:0] dmem_req_addr_o,
  output logic        dmem_req_we_o,
  output logic [63:0] dmem_req_wdata_o,
  output logic [7:0]  dmem_req_wstrb_o,
  input  logic        dmem_rsp_valid_i,
  input  logic [63:0] dmem_rsp_rdata_i,
  output logic        wb_valid_o,
  output logic [4:0]  wb_rd_o,
  output logic        wb_we_o,
  output logic [63:0] wb_data_o,
  output logic        wb_misalign_o
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_REQ    = 2'd1;
  localparam logic [1:0] S_WAIT   = 2'd2;
  localparam logic [1:0] OP_LOAD  = 2'd1;
  localparam logic [1:0] OP_STORE = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [63:0] addr_q, addr_d;
  logic [63:0] wdata_q, wdata_d;
  logic [7:0]  wstrb_q, wstrb_d;
  logic        store_q, store_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic [4:0]  rd_q, rd_d;
  logic        rd_we_q, rd_we_d;
  logic        wb_valid_q, wb_valid_d;
  logic [4:0]  wb_rd_q, wb_rd_d;
  logic        wb_we_q, wb_we_d;
  logic [63:0] wb_data_q, wb_data_d;
  logic        wb_mis_q, wb_mis_d;

  logic        is_mem;
  logic        is_store;
  logic        mis;

  function automatic logic misaligned(input logic [1:0] size, input logic [2:0] a);
    case (size)
      2'd1:    misaligned = a[0];
      2'd2:    misaligned = |a[1:0];
      2'd3:    misaligned = |a[2:0];
      default: misaligned = 1'b0;
    endcase
  endfunction

  function automatic logic [7:0] store_strb(input logic [1:0] size, input logic [2:0] off);
    case (size)
      2'd0:    store_strb = 8'h01 << off;
      2'd1:    store_strb = 8'h03 << off;
      2'd2:    store_strb = 8'h0F << off;
      default: store_strb = 8'hFF;
    endcase
  endfunction

  // Lane select by shifting the addressed byte down to bit 0, then extend.
  function automatic logic [63:0] load_extend(input logic [63:0] rdata, input logic [2:0] off,
                                              input logic [1:0] size, input logic uns);
    logic [63:0] sh;
    sh = rdata >> {off, 3'b000};
    case (size)
      2'd0:    load_extend = uns ? {56'd0, sh[7:0]}  : {{56{sh[7]}}, sh[7:0]};
      2'd1:    load_extend = uns ? {48'd0, sh[15:0]} : {{48{sh[15]}}, sh[15:0]};
      2'd2:    load_extend = uns ? {32'd0, sh[31:0]} : {{32{sh[31]}}, sh[31:0]};
      default: load_extend = sh;
    endcase
  endfunction

  assign is_mem   = (mem_op_i == OP_LOAD) || (mem_op_i == OP_STORE);
  assign is_store = (mem_op_i == OP_STORE);
  assign mis      = misaligned(mem_size_i, alu_res_i[2:0]);

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    store_d    = store_q;
    size_d     = size_q;
    uns_d      = uns_q;
    rd_d       = rd_q;
    rd_we_d    = rd_we_q;
    wb_valid_d = 1'b0;
    wb_rd_d    = wb_rd_q;
    wb_we_d    = wb_we_q;
    wb_data_d  = wb_data_q;
    wb_mis_d   = wb_mis_q;
    case (state_q)
      S_IDLE: begin
        if (ex_valid_i) begin
          if (!is_mem) begin
            wb_valid_d = 1'b1;
            wb_rd_d    = rd_i;
            wb_we_d    = rd_we_i && (rd_i != 5'd0);
            wb_data_d  = alu_res_i;
            wb_mis_d   = 1'b0;
          end else if (mis) begin
            wb_valid_d = 1'b1;
            wb_rd_d    = rd_i;
            wb_we_d    = 1'b0;
            wb_data_d  = alu_res_i;
            wb_mis_d   = 1'b1;
          end else begin
            state_d = S_REQ;
            addr_d  = alu_res_i;
            store_d = is_store;
            wdata_d = is_store ? (store_data_i << {alu_res_i[2:0], 3'b000}) : 64'd0;
            wstrb_d = is_store ? store_strb(mem_size_i, alu_res_i[2:0]) : 8'h00;
            size_d  = mem_size_i;
            uns_d   = mem_unsigned_i;
            rd_d    = rd_i;
            rd_we_d = rd_we_i && !is_store && (rd_i != 5'd0);
          end
        end
      end
      S_REQ: begin
        if (dmem_req_ready_i) begin
          if (store_q) begin
            state_d    = S_IDLE;
            wb_valid_d = 1'b1;
            wb_rd_d    = rd_q;
            wb_we_d    = 1'b0;
            wb_data_d  = addr_q;
            wb_mis_d   = 1'b0;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (dmem_rsp_valid_i) begin
          state_d    = S_IDLE;
          wb_valid_d = 1'b1;
          wb_rd_d    = rd_q;
          wb_we_d    = rd_we_q;
          wb_data_d  = load_extend(dmem_rsp_rdata_i, addr_q[2:0], size_q, uns_q);
          wb_mis_d   = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      store_q    <= 1'b0;
      size_q     <= '0;
      uns_q      <= 1'b0;
      rd_q       <= '0;
      rd_we_q    <= 1'b0;
      wb_valid_q <= 1'b0;
      wb_rd_q    <= '0;
      wb_we_q    <= 1'b0;
      wb_data_q  <= '0;
      wb_mis_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      store_q    <= store_d;
      size_q     <= size_d;
      uns_q      <= uns_d;
      rd_q       <= rd_d;
      rd_we_q    <= rd_we_d;
      wb_valid_q <= wb_valid_d;
      wb_rd_q    <= wb_rd_d;
      wb_we_q    <= wb_we_d;
      wb_data_q  <= wb_data_d;
      wb_mis_q   <= wb_mis_d;
    end
  end

  assign ex_ready_o       = (state_q == S_IDLE);
  assign dmem_req_valid_o = (state_q == S_REQ);
  assign dmem_req_addr_o  = {addr_q[63:3], 3'b000};
  assign dmem_req_we_o    = store_q;
  assign dmem_req_wdata_o = wdata_q;
  assign dmem_req_wstrb_o = wstrb_q;
  assign wb_valid_o       = wb_valid_q;
  assign wb_rd_o          = wb_rd_q;
  assign wb_we_o          = wb_we_q;
  assign wb_data_o        = wb_data_q;
  assign wb_misalign_o    = wb_mis_q;

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access: ALU pass-through, stores, loads, misalignment,
// spurious responses and reset during an outstanding load.
module tb_mem_access;
  logic        clk = 1'b0;
  logic        resetn;
  logic        ex_valid_i;
  logic        ex_ready_o;
  logic [63:0] alu_res_i;
  logic [63:0] store_data_i;
  logic [1:0]  mem_op_i;
  logic [1:0]  mem_size_i;
  logic        mem_unsigned_i;
  logic [4:0]  rd_i;
  logic        rd_we_i;
  logic        dmem_req_valid_o;
  logic        dmem_req_ready_i;
  logic [63:0] dmem_req_addr_o;
  logic        dmem_req_we_o;
  logic [63:0] dmem_req_wdata_o;
  logic [7:0]  dmem_req_wstrb_o;
  logic        dmem_rsp_valid_i;
  logic [63:0] dmem_rsp_rdata_i;
  logic        wb_valid_o;
  logic [4:0]  wb_rd_o;
  logic        wb_we_o;
  logic [63:0] wb_data_o;
  logic        wb_misalign_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_access dut (
    .clk(clk), .resetn(resetn),
    .ex_valid_i(ex_valid_i), .ex_ready_o(ex_ready_o),
    .alu_res_i(alu_res_i), .store_data_i(store_data_i),
    .mem_op_i(mem_op_i), .mem_size_i(mem_size_i), .mem_unsigned_i(mem_unsigned_i),
    .rd_i(rd_i), .rd_we_i(rd_we_i),
    .dmem_req_valid_o(dmem_req_valid_o), .dmem_req_ready_i(dmem_req_ready_i),
    .dmem_req_addr_o(dmem_req_addr_o), .dmem_req_we_o(dmem_req_we_o),
    .dmem_req_wdata_o(dmem_req_wdata_o), .dmem_req_wstrb_o(dmem_req_wstrb_o),
    .dmem_rsp_valid_i(dmem_rsp_valid_i), .dmem_rsp_rdata_i(dmem_rsp_rdata_i),
    .wb_valid_o(wb_valid_o), .wb_rd_o(wb_rd_o), .wb_we_o(wb_we_o),
    .wb_data_o(wb_data_o), .wb_misalign_o(wb_misalign_o)
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    ex_valid_i       = 1'b0;
    alu_res_i        = '0;
    store_data_i     = '0;
    mem_op_i         = 2'd0;
    mem_size_i       = 2'd0;
    mem_unsigned_i   = 1'b0;
    rd_i             = '0;
    rd_we_i          = 1'b0;
    dmem_req_ready_i = 1'b0;
    dmem_rsp_valid_i = 1'b0;
    dmem_rsp_rdata_i = '0;
  endtask

  task automatic test_reset;
    logic [5:0]   ctl;
    logic [208:0] dat;
    resetn = 1'b0;
    idle_inputs();
    repeat (2) step();
    ctl = {dmem_req_valid_o, dmem_req_we_o, wb_valid_o, wb_we_o, wb_misalign_o, ex_ready_o};
    checks++;
    if (ctl !== 6'b000001) begin
      errors++;
      $display("FAIL reset_ctl got %b exp %b", ctl, 6'b000001);
    end
    dat = {dmem_req_addr_o, dmem_req_wdata_o, dmem_req_wstrb_o, wb_rd_o, wb_data_o};
    checks++;
    if (dat !== '0) begin
      errors++;
      $display("FAIL reset_data got %h exp 0", dat);
    end
    #3 resetn = 1'b1;
    step();
  endtask

  task automatic test_alu;
    logic [71:0] got, exp;
    ex_valid_i = 1'b1; mem_op_i = 2'd0; alu_res_i = 64'h1234; rd_i = 5'd5; rd_we_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      got = {wb_valid_o, wb_we_o, wb_rd_o, wb_data_o, dmem_req_valid_o};
      exp = {1'b1, 1'b1, 5'd5, 64'h1234, 1'b0};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL alu_b2b_%0d got %h exp %h", i, got, exp);
      end
    end
    // reserved op behaves as NONE; rd=0 suppresses the write
    mem_op_i = 2'd3; alu_res_i = 64'h55; rd_i = 5'd0;
    step();
    got = {wb_valid_o, wb_we_o, wb_rd_o, wb_data_o, dmem_req_valid_o};
    exp = {1'b1, 1'b0, 5'd0, 64'h55, 1'b0};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL alu_reserved got %h exp %h", got, exp);
    end
    idle_inputs();
    step();
    checks++;
    if ({wb_valid_o, wb_data_o} !== {1'b0, 64'h55}) begin
      errors++;
      $display("FAIL alu_pulse_hold got %h exp %h", {wb_valid_o, wb_data_o}, {1'b0, 64'h55});
    end
  endtask

  task automatic test_store(input string nm, input logic [63:0] addr, input logic [1:0] size,
                            input logic [63:0] data, input int delay, input logic [63:0] exp_addr,
                            input logic [7:0] exp_strb, input logic [63:0] exp_wdata);
    logic [139:0] got, exp;
    ex_valid_i = 1'b1; mem_op_i = 2'd2; mem_size_i = size; alu_res_i = addr;
    store_data_i = data; rd_i = 5'd7; rd_we_i = 1'b1; dmem_req_ready_i = 1'b0;
    step();
    ex_valid_i = 1'b0;
    exp = {1'b1, 1'b1, 1'b0, 1'b0, exp_addr, exp_strb, exp_wdata};
    for (int i = 0; i <= delay; i++) begin
      got = {dmem_req_valid_o, dmem_req_we_o, ex_ready_o, wb_valid_o,
             dmem_req_addr_o, dmem_req_wstrb_o, dmem_req_wdata_o};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL %s_req_%0d got %h exp %h", nm, i, got, exp);
      end
      if (i == delay) dmem_req_ready_i = 1'b1;
      step();
    end
    dmem_req_ready_i = 1'b0;
    checks++;
    if ({wb_valid_o, wb_we_o, wb_misalign_o, ex_ready_o, dmem_req_valid_o, wb_rd_o}
        !== {5'b10010, 5'd7}) begin
      errors++;
      $display("FAIL %s_retire got %b exp %b", nm,
               {wb_valid_o, wb_we_o, wb_misalign_o, ex_ready_o, dmem_req_valid_o, wb_rd_o},
               {5'b10010, 5'd7});
    end
    step();
    checks++;
    if (wb_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL %s_pulse got %b exp 0", nm, wb_valid_o);
    end
  endtask

  task automatic test_load(input string nm, input logic [63:0] addr, input logic [1:0] size,
                           input logic uns, input logic [4:0] rd, input logic [63:0] rdata,
                           input logic [63:0] exp_data, input logic exp_we);
    logic [72:0] got, exp;
    ex_valid_i = 1'b1; mem_op_i = 2'd1; mem_size_i = size; mem_unsigned_i = uns;
    alu_res_i = addr; rd_i = rd; rd_we_i = 1'b1;
    step();
    ex_valid_i = 1'b0;
    got = {dmem_req_valid_o, dmem_req_addr_o, dmem_req_wstrb_o};
    exp = {1'b1, addr & ~64'h7, 8'h00};
    checks++;
    if (got !== exp || dmem_req_we_o !== 1'b0) begin
      errors++;
      $display("FAIL %s_req got %h we %b exp %h we 0", nm, got, dmem_req_we_o, exp);
    end
    dmem_req_ready_i = 1'b1;
    step();
    dmem_req_ready_i = 1'b0;
    checks++;
    if ({dmem_req_valid_o, wb_valid_o, ex_ready_o} !== 3'b000) begin
      errors++;
      $display("FAIL %s_wait got %b exp 000", nm, {dmem_req_valid_o, wb_valid_o, ex_ready_o});
    end
    dmem_rsp_valid_i = 1'b1; dmem_rsp_rdata_i = rdata;
    step();
    dmem_rsp_valid_i = 1'b0; dmem_rsp_rdata_i = 64'h5A5A_5A5A_5A5A_5A5A;
    got = {1'b0, wb_valid_o, wb_we_o, wb_misalign_o, ex_ready_o, wb_rd_o, wb_data_o};
    exp = {1'b0, 1'b1, exp_we, 1'b0, 1'b1, rd, exp_data};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s_retire got %h exp %h", nm, got, exp);
    end
    step();
    checks++;
    if (wb_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL %s_pulse got %b exp 0", nm, wb_valid_o);
    end
  endtask

  task automatic test_misalign(input string nm, input logic [1:0] op, input logic [1:0] size,
                               input logic [63:0] addr);
    logic [68:0] got, exp;
    ex_valid_i = 1'b1; mem_op_i = op; mem_size_i = size; alu_res_i = addr;
    store_data_i = 64'hFFFF; rd_i = 5'd3; rd_we_i = 1'b1;
    step();
    ex_valid_i = 1'b0;
    got = {wb_valid_o, wb_misalign_o, wb_we_o, wb_data_o, dmem_req_valid_o, ex_ready_o};
    exp = {1'b1, 1'b1, 1'b0, addr, 1'b0, 1'b1};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", nm, got, exp);
    end
    step();
    checks++;
    if ({wb_valid_o, dmem_req_valid_o} !== 2'b00) begin
      errors++;
      $display("FAIL %s_after got %b exp 00", nm, {wb_valid_o, dmem_req_valid_o});
    end
  endtask

  task automatic test_spurious;
    dmem_rsp_valid_i = 1'b1; dmem_rsp_rdata_i = 64'h1111; dmem_req_ready_i = 1'b1;
    repeat (2) step();
    dmem_rsp_valid_i = 1'b0; dmem_req_ready_i = 1'b0;
    checks++;
    if ({wb_valid_o, ex_ready_o, dmem_req_valid_o} !== 3'b010) begin
      errors++;
      $display("FAIL spurious got %b exp 010", {wb_valid_o, ex_ready_o, dmem_req_valid_o});
    end
  endtask

  task automatic test_reset_midflight;
    ex_valid_i = 1'b1; mem_op_i = 2'd1; mem_size_i = 2'd3; alu_res_i = 64'h3000;
    rd_i = 5'd9; rd_we_i = 1'b1;
    step();
    ex_valid_i = 1'b0; dmem_req_ready_i = 1'b1;
    step();
    dmem_req_ready_i = 1'b0;
    checks++;
    if (ex_ready_o !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_wait got ex_ready %b exp 0", ex_ready_o);
    end
    resetn = 1'b0;
    #1;
    checks++;
    if ({dmem_req_valid_o, dmem_req_we_o, wb_valid_o, wb_we_o, wb_misalign_o, ex_ready_o,
         dmem_req_addr_o, wb_data_o, wb_rd_o} !== {6'b000001, 133'd0}) begin
      errors++;
      $display("FAIL rst_mid_outputs got %h exp %h",
               {dmem_req_valid_o, dmem_req_we_o, wb_valid_o, wb_we_o, wb_misalign_o, ex_ready_o,
                dmem_req_addr_o, wb_data_o, wb_rd_o}, {6'b000001, 133'd0});
    end
    #2 resetn = 1'b1;
    step();
    dmem_rsp_valid_i = 1'b1; dmem_rsp_rdata_i = 64'hDEAD;
    step();
    dmem_rsp_valid_i = 1'b0;
    checks++;
    if ({wb_valid_o, ex_ready_o} !== 2'b01) begin
      errors++;
      $display("FAIL rst_late_rsp got %b exp 01", {wb_valid_o, ex_ready_o});
    end
    step();
    checks++;
    if (wb_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL rst_late_rsp2 got %b exp 0", wb_valid_o);
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_store("sb", 64'h1003, 2'd0, 64'hAB, 3, 64'h1000, 8'h08, 64'h0000_0000_AB00_0000);
    test_store("sh", 64'h1006, 2'd1, 64'h1234_5678_9ABC_BEEF, 1, 64'h1000, 8'hC0,
               64'hBEEF_0000_0000_0000);
    test_store("sw", 64'h100C, 2'd2, 64'hFFFF_FFFF_CAFE_F00D, 0, 64'h1008, 8'hF0,
               64'hCAFE_F00D_0000_0000);
    test_store("sd", 64'h1010, 2'd3, 64'h0123_4567_89AB_CDEF, 2, 64'h1010, 8'hFF,
               64'h0123_4567_89AB_CDEF);
    test_load("lh", 64'h2006, 2'd1, 1'b0, 5'd10, 64'h8001_2222_3333_4444,
              64'hFFFF_FFFF_FFFF_8001, 1'b1);
    test_load("lhu", 64'h2006, 2'd1, 1'b1, 5'd10, 64'h8001_2222_3333_4444,
              64'h0000_0000_0000_8001, 1'b1);
    test_load("lw", 64'h2004, 2'd2, 1'b0, 5'd11, 64'h8765_4321_0000_1111,
              64'hFFFF_FFFF_8765_4321, 1'b1);
    test_load("lwu", 64'h2000, 2'd2, 1'b1, 5'd12, 64'h7777_7777_F000_000F,
              64'h0000_0000_F000_000F, 1'b1);
    test_load("lb", 64'h2001, 2'd0, 1'b0, 5'd13, 64'h1111_1111_1111_9C22,
              64'hFFFF_FFFF_FFFF_FF9C, 1'b1);
    test_load("lbu", 64'h2007, 2'd0, 1'b1, 5'd14, 64'hA511_1111_1111_1111,
              64'h0000_0000_0000_00A5, 1'b1);
    test_load("ld", 64'h2008, 2'd3, 1'b1, 5'd15, 64'hDEAD_BEEF_0123_4567,
              64'hDEAD_BEEF_0123_4567, 1'b1);
    test_load("ld_x0", 64'h2010, 2'd3, 1'b0, 5'd0, 64'h0000_0000_0000_0042,
              64'h0000_0000_0000_0042, 1'b0);
    test_spurious();
    test_misalign("mis_lw", 2'd1, 2'd2, 64'h2002);
    test_misalign("mis_sh", 2'd2, 2'd1, 64'h1001);
    test_misalign("mis_ld", 2'd1, 2'd3, 64'h2004);
    test_reset_midflight();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_access.md
# mem_access

Memory-access stage for the RV64 core, directly downstream of the combinational execute stage. Accepts the ALU result (an address for loads/stores, a final value otherwise) plus store data and control, and drives a valid/ready data-memory request with a separate response channel. Aligns and extends load data, builds store byte strobes, flags misaligned accesses, and hands one registered result per instruction to writeback.

## Interface
- Parameters: none; widths are fixed at XLEN=64, 5-bit register index.
- clk  in  1  core clock, all state on rising edge
- resetn  in  1  asynchronous, active-low reset
- ex_valid_i  in  1  execute result valid
- ex_ready_o  out  1  stage can accept; equals (state==IDLE)
- alu_res_i  in  64  ALU result / effective address
- store_data_i  in  64  rs2 value for stores
- mem_op_i  in  2  0=NONE, 1=LOAD, 2=STORE, 3=reserved (treated as NONE)
- mem_size_i  in  2  0=B, 1=H, 2=W, 3=D
- mem_unsigned_i  in  1  zero-extend load (LBU/LHU/LWU)
- rd_i  in  5  destination register
- rd_we_i  in  1  instruction writes rd
- dmem_req_valid_o  out  1  memory request valid
- dmem_req_ready_i  in  1  memory accepts request
- dmem_req_addr_o  out  64  address with [2:0] forced to 0
- dmem_req_we_o  out  1  1=store
- dmem_req_wdata_o  out  64  store data shifted to byte lane
- dmem_req_wstrb_o  out  8  byte enables (stores only; 0 for loads)
- dmem_rsp_valid_i  in  1  load data valid
- dmem_rsp_rdata_i  in  64  aligned 8-byte load data
- wb_valid_o  out  1  one-cycle retire pulse to writeback
- wb_rd_o  out  5  destination register
- wb_we_o  out  1  register write enable
- wb_data_o  out  64  write-back value
- wb_misalign_o  out  1  misaligned-access exception with this retire

## Operation
- States: IDLE, REQ, WAIT_RSP. Reset -> IDLE.
- IDLE, ex_valid_i=1 (handshake): capture all inputs.
  - mem_op NONE/reserved: wb_valid next cycle, wb_data=alu_res_i, stay IDLE.
  - Misaligned (H: addr[0]!=0; W: addr[1:0]!=0; D: addr[2:0]!=0): no request; wb_valid next cycle, wb_misalign_o=1, wb_we_o=0, wb_data=address; stay IDLE.
  - Aligned LOAD/STORE: go REQ.
- REQ: dmem_req_valid_o=1; addr/we/wdata/wstrb held stable until dmem_req_ready_i. On ready: STORE -> IDLE with wb_valid same edge (wb_we_o=0); LOAD -> WAIT_RSP.
- WAIT_RSP: on dmem_rsp_valid_i, take byte offset off=addr[2:0], select lane, sign-extend (zero-extend if mem_unsigned) to 64 b, wb_valid next cycle, -> IDLE. D ignores mem_unsigned.
- Store lane rules: wstrb B=1<<off, H=3<<off, W=0xF<<off, D=0xFF; wdata=store_data_i<<(8*off).
- wb_we_o = rd_we_i & (op!=STORE) & !misalign & (rd_i!=0).
- dmem_rsp_valid_i outside WAIT_RSP ignored. dmem_req_ready_i outside REQ ignored.
- Writeback never back-pressures.

## Timing
- Reset (async assert): state IDLE; dmem_req_valid_o, dmem_req_we_o, wb_valid_o, wb_we_o, wb_misalign_o = 0; all data/addr/strb/rd outputs = 0; ex_ready_o=1.
- Handshake at edge N: NONE/misaligned -> wb_valid cycle N+1; throughput 1/cycle.
- Store: req_valid from N+1; ready at cycle M -> wb_valid M+1, ex_ready_o=1 in M+1.
- Load: req_valid from N+1; ready at M; rsp at earliest M+1, at cycle R -> wb_valid R+1.
- wb_valid_o is a single-cycle pulse; wb_* fields hold last value otherwise.
- ex_ready_o purely from state; accept allowed in the same cycle a memory op's wb_valid pulses.
- Reset mid-transaction: request dropped, outstanding response discarded after reset release.

## Test plan
- ALU op: alu_res=0x1234, rd=5, rd_we=1, back-to-back 3 ops -> wb_valid each cycle, wb_data=0x1234, wb_we=1, no dmem_req_valid.
- Store SB addr=0x1003 data=0xAB, ready delayed 3 cycles -> addr 0x1000, wstrb=0x08, wdata[31:24]=0xAB, fields stable while stalled, wb_valid 1 cycle after ready, wb_we=0.
- Load LH addr=0x2006, rdata=0x8001_xxxx_xxxx_xxxx -> wb_data=0xFFFF_FFFF_FFFF_8001; LHU same -> 0x8001.
- Load LW addr=0x2002 -> no request, wb_misalign=1, wb_we=0, wb_data=0x2002.
- Load with rd=0 -> request issued, wb_valid=1, wb_we=0; spurious rsp_valid in IDLE ignored.
- resetn low during WAIT_RSP -> all outputs 0 immediately, ex_ready=1; late rsp_valid after release produces no wb_valid.
